kernel_helper_mc: RTL and testbench
===================================

# kernel_helper_mc

Multi-kernel control helper sitting between the infrastructure AXI-Lite control port and a group of up to NUM_KERNELS HLS kernel instances sharing one control slave. It forwards ordinary register traffic to the kernel port and terminates the special register window locally. It provides ACTION_TYPE and RELEASE_LEVEL readback, per-channel 64-bit interrupt source registers and a context register. It converts per-kernel level interrupts into a single round-robin arbitrated req/ack interrupt stream toward the infrastructure.

## Interface
- ACTION_TYPE, 32'h10143FFF, value returned at special offset 0x10
- RELEASE_LEVEL, 32'h00000001, value returned at special offset 0x14
- SPECIAL_REG_BASE, 32'h00001000, base of locally terminated window (window = base .. base+0xFFF)
- NUM_KERNELS, 4, interrupt channels, 1..32
- CTXW, 9, context ID width
- C_S_AXI_CONTROL_ADDR_WIDTH, 6, kernel-side address width (data fixed 32)
- clk  in  1  clock; resetn  in  1  reset, synchronous, active-low
- interrupt_i  in  NUM_KERNELS  level interrupt per kernel
- interrupt_req  out  1  held high until interrupt_ack
- interrupt_src  out  64  source of granted channel; interrupt_ctx  out  CTXW  context register
- interrupt_chan  out  $clog2(NUM_KERNELS) (min 1)  granted channel index
- interrupt_ack  in  1  completes the request
- s_axilite_*  AXI-Lite slave, 32-bit addr/data (aw/w/b/ar/r channels, resp 2 bits)
- s_axi_control_*  AXI-Lite master to kernel, addr C_S_AXI_CONTROL_ADDR_WIDTH, data 32

## Operation
- Local window: addr[31:12]==SPECIAL_REG_BASE[31:12]; everything else forwarded with addr truncated to C_S_AXI_CONTROL_ADDR_WIDTH.
- Local map (offsets): 0x10 ACTION_TYPE RO; 0x14 RELEASE_LEVEL RO; 0x18 PENDING RO (bit i = channel i pending); 0x1C CTX RW [CTXW-1:0]; 0x100+8i SRC_LO[i] RW; 0x104+8i SRC_HI[i] RW. Unmapped local reads return 0, unmapped/RO writes ignored; resp always OKAY. WSTRB honoured per byte on RW registers.
- Write path: AW and W accepted together (awready=wready=1 in the same cycle) only when both valid and no write outstanding. Route is latched from awaddr; forwarded writes present AW/W to kernel and wait for kernel BVALID, whose BRESP is returned unchanged. Read path: one read outstanding; route latched at AR handshake; kernel RDATA/RRESP returned unchanged.
- Interrupt edge detect: rising edge of interrupt_i[i] sets pending[i]. Edge on channel i in the cycle its ack arrives leaves pending[i] set (new event). Edges on an already pending channel merge.
- Arbiter FSM: IDLE -> REQ when any pending; grant = first pending at or after (last_grant+1) mod NUM_KERNELS; interrupt_src/chan latched at grant. REQ -> IDLE on interrupt_ack, clearing pending[grant] and updating last_grant. SRC writes during REQ do not change the latched interrupt_src.

## Timing
- Reset: interrupt_req=0, interrupt_src=0, interrupt_chan=0, interrupt_ctx=0, all SRC/CTX/pending=0, last_grant=NUM_KERNELS-1, s_axilite ready/valid outputs 0, s_axi_control valid outputs 0.
- Local write: bvalid the cycle after AW/W handshake, held until bready. Local read: rvalid the cycle after AR handshake, held until rready.
- Forwarded: one register stage each direction; kernel sees AWVALID/WVALID/ARVALID the cycle after the slave handshake, held until its ready.
- Interrupt: edge at cycle N -> pending at N+1 -> interrupt_req at N+2 (if idle). Ack at cycle M -> req low at M+1; next grant earliest at M+2.
- interrupt_ack while interrupt_req is low is ignored.
- Reset mid-transaction drops all outstanding state; no response is issued.

## Configuration
- KERNEL_HELPER_IRQ_COUNT_EN defined: per-channel 16-bit saturating counters of detected rising edges (including merged ones), read at offset 0x200+4i; a write of any value clears channel i. Undefined: counters absent, 0x200 range reads 0.

## Test plan
- Read base+0x10 then base+0x14 -> rdata 0x10143FFF then 0x00000001, kernel ARVALID never asserted.
- Write 0x1234 to addr 0x08 -> kernel AWADDR=6'h08, WDATA=0x1234; kernel BRESP=2'b10 returned as bresp 2'b10.
- Write SRC_LO[2]=0xAAAA0000, SRC_HI[2]=0x5; pulse interrupt_i[2] -> req with src=0x00000005AAAA0000, chan=2; after ack PENDING reads 0.
- Raise interrupt_i[0] and interrupt_i[3] same cycle (last_grant=3) -> grant 0 first, then 3 after ack.
- Rising edge on channel 1 in the ack cycle of channel 1 -> second request for channel 1 issued at ack+2.
- With KERNEL_HELPER_IRQ_COUNT_EN: 3 edges on channel 0 before ack -> 0x200 reads 3, one request only; write 0x200 -> reads 0.

Source files
------------

// File: rtl/kernel_helper_mc_if.sv
// AXI-Lite channel bundle (32-bit data, parameterised address) used for both
// the infrastructure-side slave port and the kernel-side master port.
interface kernel_helper_mc_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/kernel_helper_mc.sv
// Multi-kernel control helper: local special-register window, AXI-Lite forwarding
// and round-robin interrupt arbitration. Optional edge counters: KERNEL_HELPER_IRQ_COUNT_EN.
module kernel_helper_mc #(
    parameter logic [31:0] ACTION_TYPE                = 32'h10143FFF,
    parameter logic [31:0] RELEASE_LEVEL              = 32'h00000001,
    parameter logic [31:0] SPECIAL_REG_BASE           = 32'h00001000,
    parameter int          NUM_KERNELS                = 4,
    parameter int          CTXW                       = 9,
    parameter int          C_S_AXI_CONTROL_ADDR_WIDTH = 6,
    localparam int         CHW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    kernel_helper_mc_if.slave      s_axilite,
    kernel_helper_mc_if.master     s_axi_control,
    input  logic [NUM_KERNELS-1:0] interrupt_i,
    output logic                   interrupt_req_o,
    output logic [63:0]            interrupt_src_o,
    output logic [CTXW-1:0]        interrupt_ctx_o,
    output logic [CHW-1:0]         interrupt_chan_o,
    input  logic                   interrupt_ack_i
);
    localparam int         AW         = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [9:0] W_ACTION   = 10'h004;
    localparam logic [9:0] W_RELEASE  = 10'h005;
    localparam logic [9:0] W_PENDING  = 10'h006;
    localparam logic [9:0] W_CTX      = 10'h007;

    typedef enum logic {ST_IDLE, ST_REQ} irq_state_e;

    // Word index of SRC_LO[i] (hi=0) or SRC_HI[i] (hi=1) inside the local window.
    function automatic logic [9:0] src_word(input int i, input int hi);
        return 10'(64 + 2 * i + hi);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    logic [CTXW-1:0]        ctx_q;
    logic [31:0]            src_lo_q [NUM_KERNELS];
    logic [31:0]            src_hi_q [NUM_KERNELS];
    logic [NUM_KERNELS-1:0] pending_q, pending_d;
    logic [NUM_KERNELS-1:0] irq_q, rise;

    // ---------------- write path ----------------
    logic          wr_busy_q, wr_local_q, bvalid_q;
    logic [1:0]    bresp_q;
    logic          k_awvalid_q, k_wvalid_q;
    logic [AW-1:0] k_awaddr_q;
    logic [31:0]   k_wdata_q;
    logic [3:0]    k_wstrb_q;
    logic          wr_hs, wr_is_local, lw_en, k_bready;
    logic [9:0]    wr_word;

    assign wr_is_local = (s_axilite.awaddr[31:12] == SPECIAL_REG_BASE[31:12]);
    assign wr_word     = s_axilite.awaddr[11:2];
    assign wr_hs       = resetn && s_axilite.awvalid && s_axilite.wvalid && !wr_busy_q;
    assign lw_en       = wr_hs && wr_is_local;
    assign k_bready    = wr_busy_q && !wr_local_q && !bvalid_q;

    assign s_axilite.awready     = wr_hs;
    assign s_axilite.wready      = wr_hs;
    assign s_axilite.bvalid      = bvalid_q;
    assign s_axilite.bresp       = bresp_q;
    assign s_axi_control.awvalid = k_awvalid_q;
    assign s_axi_control.awaddr  = k_awaddr_q;
    assign s_axi_control.wvalid  = k_wvalid_q;
    assign s_axi_control.wdata   = k_wdata_q;
    assign s_axi_control.wstrb   = k_wstrb_q;
    assign s_axi_control.bready  = k_bready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_busy_q   <= 1'b0;
            wr_local_q  <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            k_awvalid_q <= 1'b0;
            k_wvalid_q  <= 1'b0;
            k_awaddr_q  <= '0;
            k_wdata_q   <= '0;
            k_wstrb_q   <= '0;
        end else begin
            if (wr_hs) begin
                wr_busy_q  <= 1'b1;
                wr_local_q <= wr_is_local;
                if (wr_is_local) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= RESP_OKAY;
                end else begin
                    k_awvalid_q <= 1'b1;
                    k_wvalid_q  <= 1'b1;
                    k_awaddr_q  <= s_axilite.awaddr[AW-1:0];
                    k_wdata_q   <= s_axilite.wdata;
                    k_wstrb_q   <= s_axilite.wstrb;
                end
            end
            if (k_awvalid_q && s_axi_control.awready) k_awvalid_q <= 1'b0;
            if (k_wvalid_q && s_axi_control.wready)   k_wvalid_q  <= 1'b0;
            if (k_bready && s_axi_control.bvalid) begin
                bvalid_q <= 1'b1;
                bresp_q  <= s_axi_control.bresp;
            end
            if (bvalid_q && s_axilite.bready) begin
                bvalid_q  <= 1'b0;
                wr_busy_q <= 1'b0;
            end
        end
    end

    // ---------------- local register bank ----------------
    // NOTE: the source bank is small and must read back zero after reset, so it
    // lives in reset flops rather than an un-reset RAM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctx_q <= '0;
            for (int i = 0; i < NUM_KERNELS; i++) begin
                src_lo_q[i] <= '0;
                src_hi_q[i] <= '0;
            end
        end else if (lw_en) begin
            if (wr_word == W_CTX)
                ctx_q <= CTXW'(apply_strb(32'(ctx_q), s_axilite.wdata, s_axilite.wstrb));
            for (int i = 0; i < NUM_KERNELS; i++) begin
                if (wr_word == src_word(i, 0))
                    src_lo_q[i] <= apply_strb(src_lo_q[i], s_axilite.wdata, s_axilite.wstrb);
                if (wr_word == src_word(i, 1))
                    src_hi_q[i] <= apply_strb(src_hi_q[i], s_axilite.wdata, s_axilite.wstrb);
            end
        end
    end

`ifdef KERNEL_HELPER_IRQ_COUNT_EN
    logic [15:0] cnt_q [NUM_KERNELS];

    // A clear in the same cycle as an edge wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_KERNELS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KERNELS; i++) begin
                if (lw_en && wr_word == 10'(128 + i))
                    cnt_q[i] <= '0;
                else if (rise[i] && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end
`endif

    // ---------------- read path ----------------
    logic          rd_busy_q, rd_local_q, rvalid_q;
    logic [31:0]   rdata_q, local_rdata;
    logic [1:0]    rresp_q;
    logic          k_arvalid_q;
    logic [AW-1:0] k_araddr_q;
    logic          rd_hs, rd_is_local, k_rready;
    logic [9:0]    rd_word;

    assign rd_is_local = (s_axilite.araddr[31:12] == SPECIAL_REG_BASE[31:12]);
    assign rd_word     = s_axilite.araddr[11:2];
    assign rd_hs       = resetn && s_axilite.arvalid && !rd_busy_q;
    assign k_rready    = rd_busy_q && !rd_local_q && !rvalid_q;

    assign s_axilite.arready     = rd_hs;
    assign s_axilite.rvalid      = rvalid_q;
    assign s_axilite.rdata       = rdata_q;
    assign s_axilite.rresp       = rresp_q;
    assign s_axi_control.arvalid = k_arvalid_q;
    assign s_axi_control.araddr  = k_araddr_q;
    assign s_axi_control.rready  = k_rready;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // value held and no latch is inferred.
    always_comb begin
        local_rdata = '0;
        if (rd_word == W_ACTION)  local_rdata = ACTION_TYPE;
        if (rd_word == W_RELEASE) local_rdata = RELEASE_LEVEL;
        if (rd_word == W_PENDING) local_rdata = 32'(pending_q);
        if (rd_word == W_CTX)     local_rdata = 32'(ctx_q);
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (rd_word == src_word(i, 0)) local_rdata = src_lo_q[i];
            if (rd_word == src_word(i, 1)) local_rdata = src_hi_q[i];
`ifdef KERNEL_HELPER_IRQ_COUNT_EN
            if (rd_word == 10'(128 + i))   local_rdata = 32'(cnt_q[i]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_busy_q   <= 1'b0;
            rd_local_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            k_arvalid_q <= 1'b0;
            k_araddr_q  <= '0;
        end else begin
            if (rd_hs) begin
                rd_busy_q  <= 1'b1;
                rd_local_q <= rd_is_local;
                if (rd_is_local) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= local_rdata;
                    rresp_q  <= RESP_OKAY;
                end else begin
                    k_arvalid_q <= 1'b1;
                    k_araddr_q  <= s_axilite.araddr[AW-1:0];
                end
            end
            if (k_arvalid_q && s_axi_control.arready) k_arvalid_q <= 1'b0;
            if (k_rready && s_axi_control.rvalid) begin
                rvalid_q <= 1'b1;
                rdata_q  <= s_axi_control.rdata;
                rresp_q  <= s_axi_control.rresp;
            end
            if (rvalid_q && s_axilite.rready) begin
                rvalid_q  <= 1'b0;
                rd_busy_q <= 1'b0;
            end
        end
    end

    // ---------------- interrupt arbiter ----------------
    irq_state_e             state_q, state_d;
    logic [63:0]            src_q, src_d;
    logic [CHW-1:0]         chan_q, chan_d, last_grant_q, last_grant_d, pick;
    logic [NUM_KERNELS-1:0] clr_mask;
    logic [63:0]            pick_src;
    logic                   found;
    int                     scan_idx;

    assign rise = interrupt_i & ~irq_q;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        clr_mask     = '0;
        found        = 1'b0;
        pick         = '0;
        pick_src     = '0;
        scan_idx     = 0;
        // Round-robin: first pending channel at or after last_grant+1, wrapping.
        for (int k = 0; k < NUM_KERNELS; k++) begin
            scan_idx = int'(last_grant_q) + 1 + k;
            if (scan_idx >= NUM_KERNELS) scan_idx = scan_idx - NUM_KERNELS;
            if (!found && pending_q[scan_idx]) begin
                found    = 1'b1;
                pick     = CHW'(scan_idx);
                pick_src = {src_hi_q[scan_idx], src_lo_q[scan_idx]};
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_REQ;
                    src_d   = pick_src;
                    chan_d  = pick;
                end
            end
            ST_REQ: begin
                if (interrupt_ack_i) begin
                    state_d          = ST_IDLE;
                    last_grant_d     = chan_q;
                    clr_mask[chan_q] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge in the ack cycle re-arms the channel being cleared.
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            chan_q       <= '0;
            last_grant_q <= CHW'(NUM_KERNELS - 1);
            pending_q    <= '0;
            irq_q        <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            irq_q        <= interrupt_i;
        end
    end

    assign interrupt_req_o  = (state_q == ST_REQ);
    assign interrupt_src_o  = src_q;
    assign interrupt_chan_o = chan_q;
    assign interrupt_ctx_o  = ctx_q;
endmodule

// File: tb/tb_kernel_helper_mc.sv
// Directed scoreboard bench for kernel_helper_mc: local window, forwarding,
// round-robin interrupt arbitration and (when enabled) edge counters.
`timescale 1ns/1ps
module tb_kernel_helper_mc;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NK   = 4;
    localparam int          TMO  = 100;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NK-1:0] irq;
    logic          ack;
    logic          req;
    logic [63:0]   src;
    logic [8:0]    ctx;
    logic [1:0]    chan;

    always #5 clk = ~clk;

    kernel_helper_mc_if #(.ADDR_W(32)) s_if ();
    kernel_helper_mc_if #(.ADDR_W(6))  k_if ();

    kernel_helper_mc dut (
        .clk             (clk),
        .resetn          (resetn),
        .s_axilite       (s_if),
        .s_axi_control   (k_if),
        .interrupt_i     (irq),
        .interrupt_req_o (req),
        .interrupt_src_o (src),
        .interrupt_ctx_o (ctx),
        .interrupt_chan_o(chan),
        .interrupt_ack_i (ack)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] rd_exp_q  [$];
    logic [1:0]  wr_exp_q  [$];
    logic [65:0] irq_exp_q [$];

    // Kernel-side model state.
    logic [1:0]  k_bresp_cfg = 2'b00;
    logic [31:0] k_rdata_cfg = 32'h0;
    logic [5:0]  k_awaddr_seen = '0;
    logic [31:0] k_wdata_seen  = '0;
    logic [5:0]  k_araddr_seen = '0;
    int          k_ar_cycles   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Always-ready kernel slave: B/R one cycle after the address handshake.
    initial begin
        logic aw_f, b_f, ar_f, r_f;
        k_if.awready = 1'b1; k_if.wready = 1'b1; k_if.arready = 1'b1;
        k_if.bvalid  = 1'b0; k_if.bresp  = 2'b00;
        k_if.rvalid  = 1'b0; k_if.rdata  = '0;   k_if.rresp = 2'b00;
        forever begin
            @(negedge clk);
            aw_f = k_if.awvalid && k_if.wvalid;
            b_f  = k_if.bvalid && k_if.bready;
            ar_f = k_if.arvalid;
            r_f  = k_if.rvalid && k_if.rready;
            if (aw_f) begin
                k_awaddr_seen = k_if.awaddr;
                k_wdata_seen  = k_if.wdata;
            end
            if (ar_f) begin
                k_araddr_seen = k_if.araddr;
                k_ar_cycles++;
            end
            @(posedge clk); #1;
            if (b_f) k_if.bvalid = 1'b0;
            if (r_f) k_if.rvalid = 1'b0;
            if (aw_f) begin k_if.bvalid = 1'b1; k_if.bresp = k_bresp_cfg; end
            if (ar_f) begin k_if.rvalid = 1'b1; k_if.rdata = k_rdata_cfg; end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int lat);
        int cyc;
        logic [1:0] exp;
        @(negedge clk);
        s_if.awaddr = addr; s_if.awvalid = 1'b1;
        s_if.wdata  = data; s_if.wstrb   = strb; s_if.wvalid = 1'b1;
        s_if.bready = 1'b1;
        #1;
        cyc = 0;
        while (!(s_if.awready && s_if.wready) && cyc < TMO) begin @(negedge clk); #1; cyc++; end
        check("aw_accept", 64'(cyc < TMO), 64'd1);
        @(posedge clk); #1;
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        cyc = 0;
        while (!s_if.bvalid && cyc < TMO) begin @(posedge clk); #1; cyc++; end
        lat = cyc;
        exp = (wr_exp_q.size() != 0) ? wr_exp_q.pop_front() : 2'bxx;
        check("bresp", 64'(s_if.bresp), 64'(exp));
        @(posedge clk); #1;
        s_if.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output int lat);
        int cyc;
        logic [31:0] exp;
        @(negedge clk);
        s_if.araddr = addr; s_if.arvalid = 1'b1; s_if.rready = 1'b1;
        #1;
        cyc = 0;
        while (!s_if.arready && cyc < TMO) begin @(negedge clk); #1; cyc++; end
        check("ar_accept", 64'(cyc < TMO), 64'd1);
        @(posedge clk); #1;
        s_if.arvalid = 1'b0;
        cyc = 0;
        while (!s_if.rvalid && cyc < TMO) begin @(posedge clk); #1; cyc++; end
        lat = cyc;
        exp = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 32'hxxxxxxxx;
        check("rdata", 64'(s_if.rdata), 64'(exp));
        @(posedge clk); #1;
        s_if.rready = 1'b0;
    endtask

    task automatic pulse(input logic [NK-1:0] mask);
        @(negedge clk); irq = irq | mask;
        @(negedge clk); irq = irq & ~mask;
    endtask

    // Wait for a request, compare against the scoreboard, acknowledge for one cycle.
    task automatic service_irq(input logic [NK-1:0] raise_with_ack);
        int cyc;
        logic [65:0] e;
        cyc = 0;
        while (!req && cyc < TMO) begin @(posedge clk); #1; cyc++; end
        check("irq_seen", 64'(req), 64'd1);
        e = (irq_exp_q.size() != 0) ? irq_exp_q.pop_front() : 66'hx;
        check("irq_chan", 64'(chan), 64'(e[65:64]));
        check("irq_src", src, e[63:0]);
        ack = 1'b1;
        irq = irq | raise_with_ack;
        @(posedge clk); #1;
        ack = 1'b0;
        check("req_drop", 64'(req), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        resetn = 1'b0; irq = '0; ack = 1'b0;
        s_if.awaddr = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.araddr = '0;
        s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
        s_if.bready = 1'b0; s_if.rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_if.awready), 64'd0);
        check("rst_arready", 64'(s_if.arready), 64'd0);
        check("rst_bvalid",  64'(s_if.bvalid),  64'd0);
        check("rst_rvalid",  64'(s_if.rvalid),  64'd0);
        check("rst_k_valid", 64'({k_if.awvalid, k_if.wvalid, k_if.arvalid}), 64'd0);
        check("rst_req",  64'(req),  64'd0);
        check("rst_src",  src,       64'd0);
        check("rst_chan", 64'(chan), 64'd0);
        check("rst_ctx",  64'(ctx),  64'd0);
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
        resetn = 1'b1;

        // Identification registers, served locally.
        rd_exp_q.push_back(32'h10143FFF);
        axi_read(BASE + 32'h10, lat);
        check("local_rd_lat", 64'(lat), 64'd0);
        rd_exp_q.push_back(32'h00000001);
        axi_read(BASE + 32'h14, lat);
        check("k_ar_never", 64'(k_ar_cycles), 64'd0);

        // Forwarded traffic.
        k_bresp_cfg = 2'b10;
        wr_exp_q.push_back(2'b10);
        axi_write(32'h0000_0008, 32'h0000_1234, 4'hF, lat);
        check("fw_awaddr", 64'(k_awaddr_seen), 64'h08);
        check("fw_wdata",  64'(k_wdata_seen),  64'h1234);
        k_bresp_cfg = 2'b00;
        wr_exp_q.push_back(2'b00);
        axi_write(32'h0000_2044, 32'hDEAD_BEEF, 4'hF, lat);
        check("fw_trunc", 64'(k_awaddr_seen), 64'h04);
        k_rdata_cfg = 32'hCAFE_F00D;
        rd_exp_q.push_back(32'hCAFE_F00D);
        axi_read(32'h0000_000C, lat);
        check("fw_araddr", 64'(k_araddr_seen), 64'h0C);

        // CTX with byte strobes, RO write ignored, unmapped read zero.
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'b0001, lat);
        check("local_wr_lat", 64'(lat), 64'd0);
        rd_exp_q.push_back(32'h0000_00FF);
        axi_read(BASE + 32'h1C, lat);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h1C, 32'h0000_0100, 4'b0010, lat);
        check("ctx_out", 64'(ctx), 64'h1FF);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h10, 32'h0, 4'hF, lat);
        rd_exp_q.push_back(32'h10143FFF);
        axi_read(BASE + 32'h10, lat);
        rd_exp_q.push_back(32'h0);
        axi_read(BASE + 32'h20, lat);

        // Channel 2 source, exact request latency, SRC write during REQ.
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h110, 32'hAAAA_0000, 4'hF, lat);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h114, 32'h0000_0005, 4'hF, lat);
        irq_exp_q.push_back({2'd2, 64'h0000_0005_AAAA_0000});
        @(negedge clk); irq[2] = 1'b1;
        @(posedge clk); #1;
        check("req_n1", 64'(req), 64'd0);
        irq[2] = 1'b0;
        @(posedge clk); #1;
        check("req_n2", 64'(req), 64'd1);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h110, 32'h1111_1111, 4'hF, lat);
        check("src_latched", src, 64'h0000_0005_AAAA_0000);
        service_irq('0);
        rd_exp_q.push_back(32'h0);
        axi_read(BASE + 32'h18, lat);
        rd_exp_q.push_back(32'h1111_1111);
        axi_read(BASE + 32'h110, lat);

        // Round robin: park last_grant on 3, then 0 and 3 together.
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h100, 32'h0000_0100, 4'hF, lat);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h118, 32'h0000_0300, 4'hF, lat);
        irq_exp_q.push_back({2'd3, 64'h300});
        pulse(4'b1000);
        service_irq('0);
        irq_exp_q.push_back({2'd0, 64'h100});
        irq_exp_q.push_back({2'd3, 64'h300});
        pulse(4'b1001);
        service_irq('0);
        service_irq('0);

        // New edge on channel 1 in its own ack cycle re-requests at ack+2.
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h108, 32'h0000_0111, 4'hF, lat);
        irq_exp_q.push_back({2'd1, 64'h111});
        irq_exp_q.push_back({2'd1, 64'h111});
        pulse(4'b0010);
        service_irq(4'b0010);
        @(posedge clk); #1;
        check("req_m2", 64'(req), 64'd1);
        irq[1] = 1'b0;
        service_irq('0);
        rd_exp_q.push_back(32'h0);
        axi_read(BASE + 32'h18, lat);

        // Three merged edges on channel 0 give a single request.
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h200, 32'h0, 4'hF, lat);
        irq_exp_q.push_back({2'd0, 64'h100});
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0001);
        service_irq('0);
        repeat (5) @(posedge clk);
        #1;
        check("single_req", 64'(req), 64'd0);
`ifdef KERNEL_HELPER_IRQ_COUNT_EN
        rd_exp_q.push_back(32'd3);
        axi_read(BASE + 32'h200, lat);
        wr_exp_q.push_back(2'b00);
        axi_write(BASE + 32'h200, 32'h1234_5678, 4'hF, lat);
        rd_exp_q.push_back(32'd0);
        axi_read(BASE + 32'h200, lat);
`else
        rd_exp_q.push_back(32'd0);
        axi_read(BASE + 32'h200, lat);
`endif

        // Reset with a local read response outstanding.
        @(negedge clk);
        s_if.araddr = BASE + 32'h1C; s_if.arvalid = 1'b1; s_if.rready = 1'b0;
        @(posedge clk); #1;
        s_if.arvalid = 1'b0;
        check("rvalid_pre_rst", 64'(s_if.rvalid), 64'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rvalid_post_rst", 64'(s_if.rvalid), 64'd0);
        check("ctx_post_rst", 64'(ctx), 64'd0);
        @(negedge clk); resetn = 1'b1;
        rd_exp_q.push_back(32'h0);
        axi_read(BASE + 32'h110, lat);
        rd_exp_q.push_back(32'h0);
        axi_read(BASE + 32'h1C, lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
